i2c_fifo_ctrl: RTL and testbench
================================

// Module: i2c_fifo_ctrl
// PURPOSE
//  Dual synchronous FIFO between i2c_reg (APB side) and the I2C bit/byte engine.
//  TX FIFO: pushed by APB writes to TXR, popped by the engine.
//  RX FIFO: pushed by the engine with received bytes, popped by APB reads of RXR.
//  Also produces occupancy counts, level flags and one-cycle event pulses for the ISR.
// PARAMETERS
//  AW    4   address width; DEPTH = 2**AW entries per FIFO; occupancy width = AW+1
//  TXW  10   TX entry width: {stop, start, data[7:0]}
//  RXW   8   RX entry width
// PORTS
//  clk           in   1      system clock
//  rstn          in   1      async active-low reset
//  srstn         in   1      sync active-low soft reset/flush, from i2c_reg
//  tx_fifo_wr    in   1      push TX (APB side)
//  tx_fifo_wdat  in   TXW    TX push data
//  tx_fifo_ocy   out  AW+1   TX occupancy, 0..DEPTH
//  tx_rd         in   1      pop TX (engine side)
//  tx_rdat       out  TXW    TX head entry, first-word fall-through
//  tx_empty      out  1      TX occupancy == 0
//  tx_full       out  1      TX occupancy == DEPTH
//  rx_wr         in   1      push RX (engine side)
//  rx_wdat       in   RXW    RX push data
//  rx_fifo_ocy   out  AW+1   RX occupancy, 0..DEPTH
//  rx_fifo_rd    in   1      pop RX (APB side)
//  rx_fifo_rdat  out  RXW    RX head entry, first-word fall-through
//  rx_fifo_pirq  in   AW+1   RX threshold from i2c_reg
//  rx_empty      out  1      RX occupancy == 0
//  rx_full       out  1      RX occupancy == DEPTH
//  rx_thr        out  1      level: rx_fifo_ocy > rx_fifo_pirq
//  tx_half       out  1      level: tx_fifo_ocy <= DEPTH/2
//  tx_ovf        out  1      pulse: TX push dropped
//  rx_ovf        out  1      pulse: RX push dropped
//  rx_udf        out  1      pulse: RX pop on empty
// BEHAVIOUR
//  Reset (rstn low, async):
//   - All pointers and occupancies = 0; all pulses = 0.
//   - tx_empty = rx_empty = 1; tx_full = rx_full = 0; tx_half = 1; rx_thr = 0.
//   - Storage array is not reset. rdat outputs are don't-care while the FIFO is empty.
//  Soft reset (srstn low):
//   - Sampled at posedge; same result as rstn, taking effect on the next cycle.
//   - Overrides any push or pop in that cycle.
//  Push/pop commit on posedge clk:
//   - ocy, flags and rdat reflect the new state 1 cycle after the edge.
//   - rdat always shows the entry at the read pointer (combinational array read).
//   - i2c_reg samples rx_fifo_rdat on the same edge that pops it.
//  Per FIFO, with p = push, q = pop:
//   - p & ~full        : write at wptr; wptr+1 (wraps mod DEPTH); ocy+1.
//   - q & ~empty       : rptr+1 (wraps mod DEPTH); ocy-1.
//   - p & q, not empty : both actions; ocy unchanged. Allowed even when full.
//   - p & full & ~q    : push dropped; *_ovf pulses 1 cycle; no state change.
//   - q & empty        : pop ignored. A simultaneous push still commits.
//                        rx_udf pulses (RX only); TX pop on empty is silent.
//  Pulse timing:
//   - Pulses are registered: high exactly the cycle after the offending edge.
//   - Repeated offences give back-to-back pulses.
//  Arithmetic: ocy is AW+1 bits and must never exceed DEPTH or wrap below 0.
//  rx_thr and tx_half are combinational from registered ocy; no hysteresis.
//  There is no internal state machine beyond the pointers and counters.
// TESTING
//  1. Reset, then 16 tx_fifo_wr (0x000..0x00F)
//     -> tx_fifo_ocy = 16, tx_full = 1.
//     17th push -> tx_ovf pulse, ocy stays 16.
//     16 tx_rd -> tx_rdat sequence 0x000..0x00F, tx_empty = 1.
//  2. RX: push 0xA5, 0x5A; pulse rx_fifo_rd.
//     -> rx_fifo_rdat = 0xA5 before the pop, 0x5A after, ocy 2 -> 1.
//     Pop on empty -> rx_udf pulse, ocy stays 0.
//  3. RX full plus simultaneous rx_wr & rx_fifo_rd
//     -> no rx_ovf, ocy stays 16, data order preserved across pointer wrap.
//  4. rx_fifo_pirq = 3: push 3 -> rx_thr = 0; push 4th -> rx_thr = 1 next cycle.
//     TX: ocy 9 -> tx_half = 0; ocy 8 -> tx_half = 1.
//  5. Fill both FIFOs to 5, drive srstn low 1 cycle together with a push
//     -> both ocy = 0, empty = 1, push discarded.
//  6. Async rstn mid-burst -> all outputs at reset values immediately.
//     Normal operation resumes on the first edge after rstn rises.

Source files
------------

// File: rtl/i2c_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_fifo_ctrl_if
//  Brief    : Bus bundle between the FIFO block, the APB register side and
//             the I2C bit/byte engine.
//  Revision : 1.0
// ============================================================================
interface i2c_fifo_ctrl_if #(
    parameter int AW  = 4,
    parameter int TXW = 10,
    parameter int RXW = 8
);
    // TX side: APB pushes, engine pops
    logic           tx_fifo_wr;
    logic [TXW-1:0] tx_fifo_wdat;
    logic [AW:0]    tx_fifo_ocy;
    logic           tx_rd;
    logic [TXW-1:0] tx_rdat;
    logic           tx_empty;
    logic           tx_full;
    logic           tx_half;
    logic           tx_ovf;

    // RX side: engine pushes, APB pops
    logic           rx_wr;
    logic [RXW-1:0] rx_wdat;
    logic [AW:0]    rx_fifo_ocy;
    logic           rx_fifo_rd;
    logic [RXW-1:0] rx_fifo_rdat;
    logic [AW:0]    rx_fifo_pirq;
    logic           rx_empty;
    logic           rx_full;
    logic           rx_thr;
    logic           rx_ovf;
    logic           rx_udf;

    modport slave (
        input  tx_fifo_wr, tx_fifo_wdat, tx_rd,
        input  rx_wr, rx_wdat, rx_fifo_rd, rx_fifo_pirq,
        output tx_fifo_ocy, tx_rdat, tx_empty, tx_full, tx_half, tx_ovf,
        output rx_fifo_ocy, rx_fifo_rdat, rx_empty, rx_full, rx_thr,
        output rx_ovf, rx_udf
    );

    modport master (
        output tx_fifo_wr, tx_fifo_wdat, tx_rd,
        output rx_wr, rx_wdat, rx_fifo_rd, rx_fifo_pirq,
        input  tx_fifo_ocy, tx_rdat, tx_empty, tx_full, tx_half, tx_ovf,
        input  rx_fifo_ocy, rx_fifo_rdat, rx_empty, rx_full, rx_thr,
        input  rx_ovf, rx_udf
    );
endinterface
`default_nettype wire

// File: rtl/i2c_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_fifo_ctrl
//  Brief    : Dual first-word-fall-through FIFOs (TX and RX) with occupancy,
//             level flags and registered overflow/underflow event pulses.
//  Revision : 1.0
// ============================================================================
module i2c_fifo_ctrl #(
    parameter int AW  = 4,
    parameter int TXW = 10,
    parameter int RXW = 8
) (
    input  wire logic          clk,
    input  wire logic          rstn,
    input  wire logic          srstn,
    i2c_fifo_ctrl_if.slave     bus
);
    localparam int          c_DEPTH   = 1 << AW;
    localparam logic [AW:0] c_DEPTH_V = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] c_HALF_V  = c_DEPTH_V >> 1;
    localparam logic [AW:0] c_OCY_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    logic [TXW-1:0] tx_mem_q [c_DEPTH];
    logic [RXW-1:0] rx_mem_q [c_DEPTH];

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [AW-1:0] tx_wptr_q, tx_wptr_d;
    logic [AW-1:0] tx_rptr_q, tx_rptr_d;
    logic [AW:0]   tx_ocy_q,  tx_ocy_d;
    logic          tx_ovf_q,  tx_ovf_d;

    logic [AW-1:0] rx_wptr_q, rx_wptr_d;
    logic [AW-1:0] rx_rptr_q, rx_rptr_d;
    logic [AW:0]   rx_ocy_q,  rx_ocy_d;
    logic          rx_ovf_q,  rx_ovf_d;
    logic          rx_udf_q,  rx_udf_d;

    logic w_tx_empty, w_tx_full, w_tx_pop, w_tx_push;
    logic w_rx_empty, w_rx_full, w_rx_pop, w_rx_push;

    assign w_tx_empty = (tx_ocy_q == '0);
    assign w_tx_full  = (tx_ocy_q == c_DEPTH_V);
    assign w_rx_empty = (rx_ocy_q == '0);
    assign w_rx_full  = (rx_ocy_q == c_DEPTH_V);

    // A pop frees a slot in the same edge, so push-while-full is legal
    // whenever a real pop accompanies it. Soft reset masks both actions.
    assign w_tx_pop  = srstn & bus.tx_rd & ~w_tx_empty;
    assign w_tx_push = srstn & bus.tx_fifo_wr & (~w_tx_full | w_tx_pop);
    assign w_rx_pop  = srstn & bus.rx_fifo_rd & ~w_rx_empty;
    assign w_rx_push = srstn & bus.rx_wr & (~w_rx_full | w_rx_pop);

    always_comb begin
        tx_wptr_d = tx_wptr_q;
        tx_rptr_d = tx_rptr_q;
        tx_ocy_d  = tx_ocy_q;
        tx_ovf_d  = 1'b0;
        rx_wptr_d = rx_wptr_q;
        rx_rptr_d = rx_rptr_q;
        rx_ocy_d  = rx_ocy_q;
        rx_ovf_d  = 1'b0;
        rx_udf_d  = 1'b0;

        if (!srstn) begin
            tx_wptr_d = '0;
            tx_rptr_d = '0;
            tx_ocy_d  = '0;
            rx_wptr_d = '0;
            rx_rptr_d = '0;
            rx_ocy_d  = '0;
        end else begin
            if (w_tx_push) tx_wptr_d = tx_wptr_q + c_PTR_ONE;
            if (w_tx_pop)  tx_rptr_d = tx_rptr_q + c_PTR_ONE;
            case ({w_tx_push, w_tx_pop})
                2'b10:   tx_ocy_d = tx_ocy_q + c_OCY_ONE;
                2'b01:   tx_ocy_d = tx_ocy_q - c_OCY_ONE;
                default: tx_ocy_d = tx_ocy_q;
            endcase
            tx_ovf_d = bus.tx_fifo_wr & ~w_tx_push;

            if (w_rx_push) rx_wptr_d = rx_wptr_q + c_PTR_ONE;
            if (w_rx_pop)  rx_rptr_d = rx_rptr_q + c_PTR_ONE;
            case ({w_rx_push, w_rx_pop})
                2'b10:   rx_ocy_d = rx_ocy_q + c_OCY_ONE;
                2'b01:   rx_ocy_d = rx_ocy_q - c_OCY_ONE;
                default: rx_ocy_d = rx_ocy_q;
            endcase
            rx_ovf_d = bus.rx_wr & ~w_rx_push;
            rx_udf_d = bus.rx_fifo_rd & w_rx_empty;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_ocy_q  <= '0;
            tx_ovf_q  <= 1'b0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_ocy_q  <= '0;
            rx_ovf_q  <= 1'b0;
            rx_udf_q  <= 1'b0;
        end else begin
            tx_wptr_q <= tx_wptr_d;
            tx_rptr_q <= tx_rptr_d;
            tx_ocy_q  <= tx_ocy_d;
            tx_ovf_q  <= tx_ovf_d;
            rx_wptr_q <= rx_wptr_d;
            rx_rptr_q <= rx_rptr_d;
            rx_ocy_q  <= rx_ocy_d;
            rx_ovf_q  <= rx_ovf_d;
            rx_udf_q  <= rx_udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) tx_mem_q[tx_wptr_q] <= bus.tx_fifo_wdat;
        if (w_rx_push) rx_mem_q[rx_wptr_q] <= bus.rx_wdat;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tx_fifo_ocy  = tx_ocy_q;
    assign bus.tx_rdat      = tx_mem_q[tx_rptr_q];
    assign bus.tx_empty     = w_tx_empty;
    assign bus.tx_full      = w_tx_full;
    assign bus.tx_half      = (tx_ocy_q <= c_HALF_V);
    assign bus.tx_ovf       = tx_ovf_q;

    assign bus.rx_fifo_ocy  = rx_ocy_q;
    assign bus.rx_fifo_rdat = rx_mem_q[rx_rptr_q];
    assign bus.rx_empty     = w_rx_empty;
    assign bus.rx_full      = w_rx_full;
    assign bus.rx_thr       = (rx_ocy_q > bus.rx_fifo_pirq);
    assign bus.rx_ovf       = rx_ovf_q;
    assign bus.rx_udf       = rx_udf_q;
endmodule
`default_nettype wire

// File: tb/tb_i2c_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_fifo_ctrl
//  Brief    : Directed self-checking bench for the dual I2C FIFO block.
//  Revision : 1.0
// ============================================================================
module tb_i2c_fifo_ctrl;
    localparam int AW  = 4;
    localparam int TXW = 10;
    localparam int RXW = 8;

    logic clk;
    logic rstn;
    logic srstn;
    int   vectors;
    int   miscompares;

    i2c_fifo_ctrl_if #(.AW(AW), .TXW(TXW), .RXW(RXW)) bus ();

    i2c_fifo_ctrl #(.AW(AW), .TXW(TXW), .RXW(RXW)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .srstn (srstn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.tx_fifo_wr = 1'b0;
        bus.tx_rd      = 1'b0;
        bus.rx_wr      = 1'b0;
        bus.rx_fifo_rd = 1'b0;
    endtask

    logic [RXW-1:0] rxq [$];
    logic [RXW-1:0] exp_head;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn  = 1'b0;
        srstn = 1'b1;
        idle();
        bus.tx_fifo_wdat = '0;
        bus.rx_wdat      = '0;
        bus.rx_fifo_pirq = 5'd3;
        #12;

        // Reset values
        chk("rst_tx_ocy",   bus.tx_fifo_ocy, 0);
        chk("rst_tx_empty", bus.tx_empty, 1);
        chk("rst_tx_full",  bus.tx_full, 0);
        chk("rst_tx_half",  bus.tx_half, 1);
        chk("rst_rx_ocy",   bus.rx_fifo_ocy, 0);
        chk("rst_rx_empty", bus.rx_empty, 1);
        chk("rst_rx_full",  bus.rx_full, 0);
        chk("rst_rx_thr",   bus.rx_thr, 0);
        chk("rst_pulses",   {bus.tx_ovf, bus.rx_ovf, bus.rx_udf}, 0);
        rstn = 1'b1;
        tick();

        // 1. TX fill to 16
        for (int i = 0; i < 16; i++) begin
            bus.tx_fifo_wr   = 1'b1;
            bus.tx_fifo_wdat = 10'(i);
            tick();
            if (i == 7) chk("tx_half_at8", bus.tx_half, 1);
            if (i == 8) chk("tx_half_at9", bus.tx_half, 0);
        end
        chk("tx_ocy_full", bus.tx_fifo_ocy, 16);
        chk("tx_full",     bus.tx_full, 1);
        chk("tx_head",     bus.tx_rdat, 10'h000);
        bus.tx_fifo_wdat = 10'h3FF;
        tick();
        chk("tx_ovf_pulse", bus.tx_ovf, 1);
        chk("tx_ocy_ovf",   bus.tx_fifo_ocy, 16);
        tick();
        chk("tx_ovf_b2b", bus.tx_ovf, 1);
        idle();
        tick();
        chk("tx_ovf_clear", bus.tx_ovf, 0);

        // TX drain
        for (int i = 0; i < 16; i++) begin
            chk("tx_rdat", bus.tx_rdat, 10'(i));
            bus.tx_rd = 1'b1;
            tick();
            chk("tx_ocy_drain", bus.tx_fifo_ocy, 32'(15 - i));
            if (i == 6) chk("tx_half_drain9", bus.tx_half, 0);
            if (i == 7) chk("tx_half_drain8", bus.tx_half, 1);
        end
        chk("tx_empty", bus.tx_empty, 1);
        tick();
        chk("tx_pop_empty_ocy", bus.tx_fifo_ocy, 0);
        chk("tx_pop_empty_quiet", {bus.tx_ovf, bus.rx_udf}, 0);
        idle();

        // 2. RX basic
        bus.rx_wr = 1'b1; bus.rx_wdat = 8'hA5; tick();
        bus.rx_wdat = 8'h5A; tick();
        bus.rx_wr = 1'b0;
        chk("rx_ocy2",  bus.rx_fifo_ocy, 2);
        chk("rx_head1", bus.rx_fifo_rdat, 8'hA5);
        bus.rx_fifo_rd = 1'b1; tick();
        bus.rx_fifo_rd = 1'b0;
        chk("rx_ocy1",  bus.rx_fifo_ocy, 1);
        chk("rx_head2", bus.rx_fifo_rdat, 8'h5A);
        bus.rx_fifo_rd = 1'b1; tick();
        chk("rx_ocy0", bus.rx_fifo_ocy, 0);
        chk("rx_udf_none", bus.rx_udf, 0);
        tick();
        chk("rx_udf_pulse", bus.rx_udf, 1);
        chk("rx_udf_ocy",   bus.rx_fifo_ocy, 0);
        tick();
        chk("rx_udf_b2b", bus.rx_udf, 1);
        bus.rx_fifo_rd = 1'b0; tick();
        chk("rx_udf_clear", bus.rx_udf, 0);

        // 4. RX threshold (pirq = 3), then fill across pointer wrap
        for (int i = 0; i < 16; i++) begin
            bus.rx_wr   = 1'b1;
            bus.rx_wdat = 8'h10 + 8'(i);
            rxq.push_back(bus.rx_wdat);
            tick();
            if (i == 2) chk("rx_thr_at3", bus.rx_thr, 0);
            if (i == 3) chk("rx_thr_at4", bus.rx_thr, 1);
        end
        chk("rx_full",     bus.rx_full, 1);
        chk("rx_ocy_full", bus.rx_fifo_ocy, 16);
        bus.rx_wdat = 8'hEE; tick();
        chk("rx_ovf_pulse", bus.rx_ovf, 1);
        chk("rx_ovf_ocy",   bus.rx_fifo_ocy, 16);

        // 3. Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) begin
            exp_head = rxq.pop_front();
            chk("rx_simul_head", bus.rx_fifo_rdat, exp_head);
            bus.rx_wr      = 1'b1;
            bus.rx_fifo_rd = 1'b1;
            bus.rx_wdat    = 8'hC0 + 8'(i);
            rxq.push_back(bus.rx_wdat);
            tick();
            chk("rx_simul_noovf", bus.rx_ovf, 0);
            chk("rx_simul_ocy",   bus.rx_fifo_ocy, 16);
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            exp_head = rxq.pop_front();
            chk("rx_drain", bus.rx_fifo_rdat, exp_head);
            bus.rx_fifo_rd = 1'b1;
            tick();
        end
        idle();
        chk("rx_drain_empty", bus.rx_empty, 1);

        // 5. Soft reset overrides simultaneous pushes
        for (int i = 0; i < 5; i++) begin
            bus.tx_fifo_wr = 1'b1; bus.tx_fifo_wdat = 10'h100 + 10'(i);
            bus.rx_wr      = 1'b1; bus.rx_wdat      = 8'h60 + 8'(i);
            tick();
        end
        chk("sr_tx_ocy5", bus.tx_fifo_ocy, 5);
        chk("sr_rx_ocy5", bus.rx_fifo_ocy, 5);
        srstn = 1'b0;
        tick();
        srstn = 1'b1;
        idle();
        chk("sr_tx_ocy",   bus.tx_fifo_ocy, 0);
        chk("sr_rx_ocy",   bus.rx_fifo_ocy, 0);
        chk("sr_empties",  {bus.tx_empty, bus.rx_empty}, 2'b11);
        chk("sr_pulses",   {bus.tx_ovf, bus.rx_ovf, bus.rx_udf}, 0);
        tick();
        chk("sr_hold_tx", bus.tx_fifo_ocy, 0);
        bus.tx_fifo_wr = 1'b1; bus.tx_fifo_wdat = 10'h277; tick();
        idle();
        chk("sr_resume_rdat", bus.tx_rdat, 10'h277);
        chk("sr_resume_ocy",  bus.tx_fifo_ocy, 1);

        // 6. Async reset mid-burst
        bus.tx_fifo_wr = 1'b1; bus.tx_fifo_wdat = 10'h055;
        bus.rx_wr      = 1'b1; bus.rx_wdat      = 8'h33;
        tick(); tick();
        chk("ar_pre_tx", bus.tx_fifo_ocy, 3);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_tx_ocy",  bus.tx_fifo_ocy, 0);
        chk("ar_rx_ocy",  bus.rx_fifo_ocy, 0);
        chk("ar_flags",   {bus.tx_empty, bus.tx_full, bus.tx_half,
                           bus.rx_empty, bus.rx_full, bus.rx_thr}, 6'b101100);
        tick();
        chk("ar_hold", bus.tx_fifo_ocy, 0);
        rstn = 1'b1;
        bus.tx_fifo_wdat = 10'h0AA;
        tick();
        idle();
        chk("ar_resume_ocy",  bus.tx_fifo_ocy, 1);
        chk("ar_resume_rdat", bus.tx_rdat, 10'h0AA);
        chk("ar_resume_rx",   bus.rx_fifo_ocy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
